// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl -- sequencer between a simple valid/ready request port and
// an SRAM macro's row decoder, precharge, write drivers and sense amps.
//
// Each access walks PRE -> WL (WL_CYCLES cycles) -> [SENSE for reads] -> RESP.
// Every output is a register, so nothing combinational reaches the array pins.
//
// Parameters:
//   ADDR_WIDTH  row address width (default 6)
//   DATA_WIDTH  word width (default 8)
//   WL_CYCLES   wordline-high cycles before sense / write completion, 1..15
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (accept on valid && ready)
//   req_we, req_addr, req_wdata  request: 1 = write, word address, write data
//   rsp_valid, rsp_rdata       one-cycle completion pulse, read data
//   row_addr, row_en           row decoder address and wordline fire
//   pre_en, wdrv_en, sae       bitline precharge, write drivers, sense amps
//   array_wdata, array_rdata   data to the write drivers, from the sense amps
//
// Build option:
//   SRAM_ACCESS_CTRL_REQ_BUF_EN  adds a one-entry request buffer so a request
//   can be taken while an access is in flight and started from RESP straight
//   into PRE. Without it req_ready is high only in IDLE.
module sram_access_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int WL_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] row_addr,
  output logic                  row_en,
  output logic                  pre_en,
  output logic                  wdrv_en,
  output logic                  sae,
  output logic [DATA_WIDTH-1:0] array_wdata,
  input  logic [DATA_WIDTH-1:0] array_rdata
);

  typedef enum logic [2:0] {IDLE, PRE, WL, SENSE, RESP} state_t;

  // Loaded in PRE; WL ends on the cycle the counter reads zero.
  localparam logic [3:0] WL_LAST = 4'(WL_CYCLES - 1);

  state_t     state;
  logic [3:0] wl_cnt;
  logic       we_q;
  logic       accept;

  assign accept = req_valid && req_ready;

`ifdef SRAM_ACCESS_CTRL_REQ_BUF_EN
  logic                  buf_full;
  logic                  buf_we;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [DATA_WIDTH-1:0] buf_wdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      row_en      <= 1'b0;
      pre_en      <= 1'b0;
      wdrv_en     <= 1'b0;
      sae         <= 1'b0;
      row_addr    <= '0;
      array_wdata <= '0;
      rsp_rdata   <= '0;
      wl_cnt      <= '0;
      we_q        <= 1'b0;
`ifdef SRAM_ACCESS_CTRL_REQ_BUF_EN
      buf_full    <= 1'b0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= '0;
`endif
    end else begin
      // Array strobes are single-purpose pulses: default low every cycle.
      rsp_valid <= 1'b0;
      pre_en    <= 1'b0;
      row_en    <= 1'b0;
      wdrv_en   <= 1'b0;
      sae       <= 1'b0;
`ifdef SRAM_ACCESS_CTRL_REQ_BUF_EN
      req_ready <= !buf_full;
`else
      req_ready <= 1'b0;
`endif

      case (state)
        IDLE: begin
`ifndef SRAM_ACCESS_CTRL_REQ_BUF_EN
          req_ready <= !accept;
`endif
          if (accept) begin
            row_addr    <= req_addr;
            array_wdata <= req_wdata;
            we_q        <= req_we;
            pre_en      <= 1'b1;
            state       <= PRE;
          end
        end

        PRE: begin
          row_en  <= 1'b1;
          wdrv_en <= we_q;
          wl_cnt  <= WL_LAST;
          state   <= WL;
        end

        WL: begin
          if (wl_cnt == 4'd0) begin
            if (we_q) begin
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              // Wordline stays up through the sense cycle.
              row_en <= 1'b1;
              sae    <= 1'b1;
              state  <= SENSE;
            end
          end else begin
            wl_cnt  <= wl_cnt - 4'd1;
            row_en  <= 1'b1;
            wdrv_en <= we_q;
          end
        end

        SENSE: begin
          rsp_rdata <= array_rdata;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end

        RESP: begin
`ifdef SRAM_ACCESS_CTRL_REQ_BUF_EN
          if (buf_full) begin
            row_addr    <= buf_addr;
            array_wdata <= buf_wdata;
            we_q        <= buf_we;
            buf_full    <= 1'b0;
            req_ready   <= 1'b1;
            pre_en      <= 1'b1;
            state       <= PRE;
          end else if (accept) begin
            // A request arriving as the access finishes starts immediately
            // instead of parking in the buffer for a cycle.
            row_addr    <= req_addr;
            array_wdata <= req_wdata;
            we_q        <= req_we;
            pre_en      <= 1'b1;
            state       <= PRE;
          end else begin
            state <= IDLE;
          end
`else
          req_ready <= 1'b1;
          state     <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase

`ifdef SRAM_ACCESS_CTRL_REQ_BUF_EN
      // Mid-access accepts park here; ready drops until RESP drains the entry.
      if (accept && (state == PRE || state == WL || state == SENSE)) begin
        buf_full  <= 1'b1;
        buf_we    <= req_we;
        buf_addr  <= req_addr;
        buf_wdata <= req_wdata;
        req_ready <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
module tb_sram_access_ctrl;
  localparam int AW = 6;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Index 0: WL_CYCLES=1 instance, index 1: WL_CYCLES=3 instance.
  logic [1:0]         req_valid, req_we;
  logic [1:0][AW-1:0] req_addr;
  logic [1:0][DW-1:0] req_wdata, array_rdata;

  wire          r0_req_ready, r0_rsp_valid, r0_row_en, r0_pre_en, r0_wdrv_en, r0_sae;
  wire [DW-1:0] r0_rsp_rdata, r0_array_wdata;
  wire [AW-1:0] r0_row_addr;
  wire          r1_req_ready, r1_rsp_valid, r1_row_en, r1_pre_en, r1_wdrv_en, r1_sae;
  wire [DW-1:0] r1_rsp_rdata, r1_array_wdata;
  wire [AW-1:0] r1_row_addr;

  wire [1:0]         req_ready   = {r1_req_ready, r0_req_ready};
  wire [1:0]         rsp_valid   = {r1_rsp_valid, r0_rsp_valid};
  wire [1:0]         row_en      = {r1_row_en, r0_row_en};
  wire [1:0]         pre_en      = {r1_pre_en, r0_pre_en};
  wire [1:0]         wdrv_en     = {r1_wdrv_en, r0_wdrv_en};
  wire [1:0]         sae         = {r1_sae, r0_sae};
  wire [1:0][DW-1:0] rsp_rdata   = {r1_rsp_rdata, r0_rsp_rdata};
  wire [1:0][DW-1:0] array_wdata = {r1_array_wdata, r0_array_wdata};
  wire [1:0][AW-1:0] row_addr    = {r1_row_addr, r0_row_addr};

  sram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WL_CYCLES(1)) u_dut_wl1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(r0_req_ready), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(r0_rsp_valid), .rsp_rdata(r0_rsp_rdata),
    .row_addr(r0_row_addr), .row_en(r0_row_en), .pre_en(r0_pre_en),
    .wdrv_en(r0_wdrv_en), .sae(r0_sae),
    .array_wdata(r0_array_wdata), .array_rdata(array_rdata[0])
  );

  sram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WL_CYCLES(3)) u_dut_wl3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(r1_req_ready), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(r1_rsp_valid), .rsp_rdata(r1_rsp_rdata),
    .row_addr(r1_row_addr), .row_en(r1_row_en), .pre_en(r1_pre_en),
    .wdrv_en(r1_wdrv_en), .sae(r1_sae),
    .array_wdata(r1_array_wdata), .array_rdata(array_rdata[1])
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h", name, d, act, exp);
    end
  endtask

  function automatic int wl_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Called at a negedge; returns at a negedge with ready seen high, or flags.
  task automatic wait_ready(input int d);
    int n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready[d] !== 1'b1) chk("ready_timeout", d, req_ready[d], 1);
  endtask

  typedef struct {
    int          d;
    logic        we;
    logic [5:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          lat;
    int          row_cnt;
    int          sae_cnt;
    int          wdrv_cnt;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    int pre_cnt = 0, row_cnt = 0, sae_cnt = 0, wdrv_cnt = 0;
    int pre_at = -1, rsp_at = -1, sae_at = -1;
    bit addr_ok = 1'b1, overlap = 1'b0;
    logic [7:0] rd_seen = '0, wd_seen = '0;
    wait_ready(v.d);
    req_valid[v.d] = 1'b1;
    req_we[v.d] = v.we;
    req_addr[v.d] = v.addr;
    req_wdata[v.d] = v.wdata;
    array_rdata[v.d] = v.rdata;
    for (int off = 1; off <= v.lat + 1; off++) begin
      @(negedge clk);
      if (off == 1) begin
        // Request fields change after accept; the access must use the latched copy.
        req_valid[v.d] = 1'b0;
        req_addr[v.d] = ~v.addr;
        req_wdata[v.d] = ~v.wdata;
      end
      if (off <= v.lat && row_addr[v.d] !== v.addr) addr_ok = 1'b0;
      if (pre_en[v.d]) begin pre_cnt++; pre_at = off; end
      if (row_en[v.d]) row_cnt++;
      if (wdrv_en[v.d]) begin wdrv_cnt++; wd_seen = array_wdata[v.d]; end
      if (sae[v.d]) begin sae_cnt++; sae_at = off; end
      if (pre_en[v.d] && (row_en[v.d] || wdrv_en[v.d] || sae[v.d])) overlap = 1'b1;
      if (rsp_valid[v.d]) begin rsp_at = off; rd_seen = rsp_rdata[v.d]; end
    end
    chk("vec_pre_cnt", v.d, pre_cnt, 1);
    chk("vec_pre_at", v.d, pre_at, 1);
    chk("vec_row_cnt", v.d, row_cnt, v.row_cnt);
    chk("vec_sae_cnt", v.d, sae_cnt, v.sae_cnt);
    chk("vec_sae_at", v.d, sae_at, v.we ? -1 : v.lat - 1);
    chk("vec_wdrv_cnt", v.d, wdrv_cnt, v.wdrv_cnt);
    chk("vec_wdata", v.d, wd_seen, v.we ? v.wdata : 8'h00);
    chk("vec_rsp_at", v.d, rsp_at, v.lat);
    chk("vec_rdata", v.d, rd_seen, v.exp_rdata);
    chk("vec_addr_stable", v.d, addr_ok, 1);
    chk("vec_no_overlap", v.d, overlap, 0);
    chk("vec_ready_after", v.d, req_ready[v.d], 1);
  endtask

  // Reference: an accepted request at cycle a occupies cycles a+1..a+lat,
  // lat = 2+WL (write) or 3+WL (read); precharge at a+1, wordline from a+2
  // until a+lat-1, sense on a+lat-1 for reads, response on a+lat.
  task automatic run_random(input int d, input int n);
    int a = 0, lat = 0, off;
    bit have = 1'b0;
    logic mwe = 1'b0;
    logic [AW-1:0] maddr = '0;
    logic [DW-1:0] mwd = '0, mrd = '0;
    int wl = wl_of(d);
    for (int k = 0; k < n + 12; k++) begin
      bit act;
      off = k - a;
      act = have && off >= 1 && off <= lat;
      chk("rnd_ready", d, req_ready[d], !act);
      chk("rnd_pre", d, pre_en[d], act && off == 1);
      chk("rnd_row", d, row_en[d], act && off >= 2 && off <= lat - 1);
      chk("rnd_wdrv", d, wdrv_en[d], act && mwe && off >= 2 && off <= lat - 1);
      chk("rnd_sae", d, sae[d], act && !mwe && off == lat - 1);
      chk("rnd_rsp", d, rsp_valid[d], act && off == lat);
      if (have) chk("rnd_row_addr", d, row_addr[d], maddr);
      if (act && mwe) chk("rnd_wdata", d, array_wdata[d], mwd);
      if (act && !mwe && off == lat) chk("rnd_rdata", d, rsp_rdata[d], mrd);
      array_rdata[d] = DW'($urandom);
      if (act && !mwe && off == lat - 1) mrd = array_rdata[d];
      req_valid[d] = (k < n) && ($urandom_range(0, 2) != 0);
      req_we[d] = 1'($urandom);
      req_addr[d] = AW'($urandom);
      req_wdata[d] = DW'($urandom);
      if (!act && req_valid[d]) begin
        have = 1'b1;
        a = k;
        mwe = req_we[d];
        lat = (mwe ? 2 : 3) + wl;
        maddr = req_addr[d];
        mwd = req_wdata[d];
      end
      @(negedge clk);
    end
    req_valid[d] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; array_rdata = '0;

    vecs[0] = '{0, 1'b0, 6'h2A, 8'h00, 8'h5C, 4, 2, 1, 0, 8'h5C};
    vecs[1] = '{1, 1'b1, 6'h3F, 8'hA5, 8'h33, 5, 3, 0, 3, 8'h00};
    vecs[2] = '{1, 1'b0, 6'h00, 8'h00, 8'hC3, 6, 4, 1, 0, 8'hC3};
    vecs[3] = '{0, 1'b0, 6'h3F, 8'h00, 8'h01, 4, 2, 1, 0, 8'h01};
    vecs[4] = '{0, 1'b1, 6'h00, 8'h7E, 8'hEE, 3, 1, 0, 1, 8'h01};
    vecs[5] = '{1, 1'b1, 6'h15, 8'h0F, 8'h99, 5, 3, 0, 3, 8'hC3};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", d, req_ready[d], 0);
      chk("rst_ctrl", d, {rsp_valid[d], row_en[d], pre_en[d], wdrv_en[d], sae[d]}, 0);
      chk("rst_data", d, {row_addr[d], array_wdata[d], rsp_rdata[d]}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("rst_release_ready", d, req_ready[d], 1);

    // Directed single accesses
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

`ifndef SRAM_ACCESS_CTRL_REQ_BUF_EN
    // Back-to-back reads with req_valid held: second accept in the IDLE cycle.
    wait_ready(0);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 6'h11; array_rdata[0] = 8'h66;
    for (int off = 1; off <= 10; off++) begin
      @(negedge clk);
      chk("b2b_ready", 0, req_ready[0], off == 5 || off == 10);
      chk("b2b_pre", 0, pre_en[0], off == 1 || off == 6);
      chk("b2b_rsp", 0, rsp_valid[0], off == 4 || off == 9);
      if (off == 6) req_valid[0] = 1'b0;
    end

    run_random(0, 300);
    run_random(1, 300);
`else
    // Buffered back-to-back: B accepted in WL, C stalls until B starts.
    wait_ready(0);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 6'h0A; array_rdata[0] = 8'h44;
    for (int off = 1; off <= 13; off++) begin
      @(negedge clk);
      chk("buf_ready", 0, req_ready[0], !(off inside {3, 4, 6, 7, 8}));
      chk("buf_pre", 0, pre_en[0], off inside {1, 5, 9});
      chk("buf_rsp", 0, rsp_valid[0], off inside {4, 8, 12});
      if (off <= 12)
        chk("buf_row_addr", 0, row_addr[0], off <= 4 ? 6'h0A : (off <= 8 ? 6'h0B : 6'h0C));
      if (off == 1) req_valid[0] = 1'b0;
      if (off == 2) begin req_valid[0] = 1'b1; req_addr[0] = 6'h0B; end
      if (off == 3) req_addr[0] = 6'h0C;
      if (off == 6) req_valid[0] = 1'b0;
    end
`endif

    // Reset in the middle of a write's wordline phase
    begin
      bit rsp_seen = 1'b0;
      wait_ready(1);
      req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 6'h2B; req_wdata[1] = 8'h99;
      for (int off = 1; off <= 3; off++) begin
        @(negedge clk);
        if (off == 1) req_valid[1] = 1'b0;
      end
      chk("midwl_row_en", 1, {row_en[1], wdrv_en[1]}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      chk("midwl_rst_ctrl", 1, {row_en[1], wdrv_en[1], pre_en[1], sae[1], rsp_valid[1]}, 0);
      chk("midwl_rst_ready", 1, req_ready[1], 0);
      chk("midwl_rst_data", 1, {row_addr[1], array_wdata[1]}, 0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (rsp_valid[1]) rsp_seen = 1'b1;
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("midwl_ready_after", 1, req_ready[1], 1);
      chk("midwl_ready_after", 0, req_ready[0], 1);
      for (int i = 0; i < 8; i++) begin
        if (rsp_valid[1] || pre_en[1] || row_en[1]) rsp_seen = 1'b1;
        @(negedge clk);
      end
      chk("midwl_no_rsp", 1, rsp_seen, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, the row address width driven to the row decoder.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, the word width.
REQ-003 SHALL have parameter WL_CYCLES, default 1, legal range 1..15: the number of cycles the wordline stays asserted before sense or write completion.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1: access request present.
REQ-007 SHALL have port req_ready, output, 1: request accepted on a cycle where req_valid && req_ready.
REQ-008 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, ADDR_WIDTH: the word address.
REQ-010 SHALL have port req_wdata, input, DATA_WIDTH: the write data.
REQ-011 SHALL have port rsp_valid, output, 1: one-cycle completion pulse for every accepted request.
REQ-012 SHALL have port rsp_rdata, output, DATA_WIDTH: read data, valid when rsp_valid is high for a read.
REQ-013 SHALL have port row_addr, output, ADDR_WIDTH: address to the row decoder.
REQ-014 SHALL have port row_en, output, 1: the row decoder enable (wordline fire).
REQ-015 SHALL have port pre_en, output, 1: bitline precharge.
REQ-016 SHALL have port wdrv_en, output, 1: write-driver enable.
REQ-017 SHALL have port sae, output, 1: sense-amp enable.
REQ-018 SHALL have port array_wdata, output, DATA_WIDTH: data to the write drivers.
REQ-019 SHALL have port array_rdata, input, DATA_WIDTH: sense-amp outputs.

Function
REQ-020 SHALL drive all outputs from registers (Moore FSM); there is no combinational path from the inputs to any output.
REQ-021 SHALL implement the states IDLE, PRE, WL, SENSE and RESP.
REQ-022 SHALL on an accept in IDLE latch row_addr, array_wdata and the write flag, then enter PRE on the next cycle.
REQ-023 SHALL in PRE assert pre_en=1 for exactly 1 cycle with row_en=0, then enter WL.
REQ-024 SHALL in WL assert row_en=1 for exactly WL_CYCLES cycles, using a 4-bit down-counter; wdrv_en=1 throughout WL for a write.
REQ-025 SHALL go from WL to SENSE for a read: row_en=1 and sae=1 for 1 cycle, and capture rsp_rdata<=array_rdata at the end of SENSE.
REQ-026 SHALL go from WL directly to RESP for a write; rsp_rdata is unchanged by writes.
REQ-027 SHALL in RESP assert rsp_valid=1 for 1 cycle, with all array controls at 0.
REQ-028 SHALL hold row_addr stable from PRE through RESP; pre_en, row_en, wdrv_en and sae SHALL never overlap with pre_en.
REQ-029 SHALL give a latency (accept edge to rsp_valid cycle) of 3+WL_CYCLES for a read and 2+WL_CYCLES for a write.
REQ-030 SHALL hold req_ready=1 only in IDLE when the buffer feature is absent (see REQ-035).
REQ-031 SHALL not require req_valid to be held after an accept; req_valid arriving in a non-IDLE state is not accepted and no state changes.

Reset
REQ-032 SHALL on rst_n=0 immediately force: state IDLE, req_ready=0 while in reset, and all of rsp_valid, row_en, pre_en, wdrv_en, sae, row_addr, array_wdata, rsp_rdata and the counter to 0.
REQ-033 SHALL on reset mid-access abort the access with no rsp_valid, clear any buffered request, and set req_ready=1 on the first clock after rst_n rises.

Configuration
REQ-034 SHALL use the macro SRAM_ACCESS_CTRL_REQ_BUF_EN.
REQ-035 SHALL, when the macro is defined, include a one-entry request buffer:
- req_ready = buffer empty, in any state;
- a request accepted while busy is held and started from RESP straight into PRE (no IDLE cycle);
- an accept in IDLE with the buffer empty bypasses the buffer.
REQ-036 SHALL, when the macro is undefined, contain no buffer logic and behave per REQ-030.

Verification
REQ-037 SHALL cover a read with WL_CYCLES=1, addr=0x2A and array_rdata=0x5C: pre_en 1 cycle, then row_en 2 cycles with sae in the 2nd, then rsp_valid in cycle 4 after accept with rsp_rdata=0x5C and row_addr=0x2A throughout.
REQ-038 SHALL cover a write with WL_CYCLES=3, addr=0x3F and wdata=0xA5: row_en=wdrv_en=1 for 3 cycles, array_wdata=0xA5, rsp_valid in cycle 5, sae never high.
REQ-039 SHALL cover a back-to-back read with the macro undefined: req_valid held high, second accept one cycle after RESP, req_ready=0 throughout the access.
REQ-040 SHALL cover a back-to-back read with the macro defined: second request accepted during WL, PRE follows RESP directly, a third request is stalled (req_ready=0) while the buffer is full.
REQ-041 SHALL cover rst_n asserted during WL of a write: all controls drop asynchronously, no rsp_valid, req_ready=1 one clock after release.
REQ-042 SHALL cover the address boundaries 0x00 and 0x3F: row_addr matches the request for each.
